// File: rtl/tff_down_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tff_down_timer                                              |
// | Purpose  : N-bit down-counter/timer built from a chain of T flip-flops.|
// |            Loads a preset, decrements while enabled, flags terminal    |
// |            count with a one-cycle pulse and can auto-reload.           |
// | Ports    : clk         - rising-edge clock                             |
// |            rst_n       - asynchronous active-low reset                 |
// |            load        - synchronous load strobe (highest priority)    |
// |            load_val    - preset value captured on load                 |
// |            en          - count enable, one decrement per clock         |
// |            auto_reload - restart from preset after terminal count      |
// |            count       - current value, one TFF per bit                |
// |            zero        - combinational (count == 0)                    |
// |            tc_pulse    - registered one-cycle pulse on the 1 -> 0 step |
// |            busy        - high while the timer is running               |
// |            hex0        - active-low 7-seg decode of count[3:0],        |
// |                          {g,f,e,d,c,b,a}; present only when the macro  |
// |                          TFF_DOWN_TIMER_HEX_EN is defined              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tff_down_timer #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             tc_pulse,
   output logic             busy
`ifdef TFF_DOWN_TIMER_HEX_EN
   ,
   output logic [6:0]       hex0
`endif
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_reload;
   logic             r_tc;
   logic [WIDTH-1:0] w_low_zero;   // w_low_zero[i] = (q[i-1:0] == 0)
   logic [WIDTH-1:0] w_t;
   logic             w_dec;
   logic             w_reload_now;
   logic             w_is_zero;
   logic             w_is_one;

   assign w_is_zero    = (r_q == '0);
   assign w_is_one     = (r_q == C_ONE);
   assign w_dec        = (r_state == RUN) & en & ~load & ~w_is_zero;
   // Sitting at zero in RUN only happens after an auto-reload terminal count.
   assign w_reload_now = (r_state == RUN) & en & ~load & w_is_zero;

   assign w_low_zero[0] = 1'b1;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_tff
         if (i > 0) begin : g_chain
            assign w_low_zero[i] = w_low_zero[i-1] & ~r_q[i-1];
         end
         // A bit toggles on a decrement when every lower bit is zero (borrow).
         assign w_t[i] = w_dec & w_low_zero[i];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_q[i] <= 1'b0;
            end else if (load) begin
               r_q[i] <= load_val[i];
            end else if (w_reload_now) begin
               r_q[i] <= r_reload[i];
            end else if (w_t[i]) begin
               r_q[i] <= ~r_q[i];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_reload <= '0;
         r_tc     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_tc    <= w_dec & w_is_one;
         if (load) begin
            r_reload <= load_val;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (load) begin
         w_state_next = (load_val != '0) ? RUN : IDLE;
      end else if ((r_state == RUN) && en && w_is_one) begin
         // auto_reload is only looked at on the 1 -> 0 step
         w_state_next = auto_reload ? RUN : IDLE;
      end
   end

   assign count    = r_q;
   assign zero     = w_is_zero;
   assign tc_pulse = r_tc;
   assign busy     = (r_state == RUN);

`ifdef TFF_DOWN_TIMER_HEX_EN
   always_comb begin
      hex0 = 7'b1111111;
      case (r_q[3:0])
         4'h0: hex0 = 7'b1000000;
         4'h1: hex0 = 7'b1111001;
         4'h2: hex0 = 7'b0100100;
         4'h3: hex0 = 7'b0110000;
         4'h4: hex0 = 7'b0011001;
         4'h5: hex0 = 7'b0010010;
         4'h6: hex0 = 7'b0000010;
         4'h7: hex0 = 7'b1111000;
         4'h8: hex0 = 7'b0000000;
         4'h9: hex0 = 7'b0010000;
         4'hA: hex0 = 7'b0001000;
         4'hB: hex0 = 7'b0000011;
         4'hC: hex0 = 7'b1000110;
         4'hD: hex0 = 7'b0100001;
         4'hE: hex0 = 7'b0000110;
         4'hF: hex0 = 7'b0001110;
         default: hex0 = 7'b1111111;
      endcase
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tff_down_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_tff_down_timer                                           |
// | Purpose  : Self-checking bench for tff_down_timer. A behavioural model |
// |            pushes expected outputs into a queue as each cycle's        |
// |            stimulus is driven; they are popped and compared after the  |
// |            clock edge. Also covers async reset and the optional hex0.  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_tff_down_timer;

   localparam int WIDTH = 10;

   typedef struct packed {
      logic [WIDTH-1:0] cnt;
      logic             z;
      logic             tc;
      logic             bsy;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             en;
   logic             auto_reload;
   logic [WIDTH-1:0] count;
   logic             zero;
   logic             tc_pulse;
   logic             busy;
`ifdef TFF_DOWN_TIMER_HEX_EN
   logic [6:0]       hex0;
`endif

   int checks = 0;
   int errors = 0;

   exp_t sb_q[$];

   // reference model state
   logic [WIDTH-1:0] m_cnt;
   logic [WIDTH-1:0] m_rel;
   logic             m_run;
   logic             m_tc;

   tff_down_timer #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .load_val    (load_val),
      .en          (en),
      .auto_reload (auto_reload),
      .count       (count),
      .zero        (zero),
      .tc_pulse    (tc_pulse),
      .busy        (busy)
`ifdef TFF_DOWN_TIMER_HEX_EN
      ,
      .hex0        (hex0)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = '0;
      m_rel = '0;
      m_run = 1'b0;
      m_tc  = 1'b0;
   endtask

   // Drive one cycle of stimulus, advance the model, push the expectation,
   // then compare the DUT after the edge against the popped entry.
   task automatic step(input logic ld, input logic [WIDTH-1:0] lv,
                       input logic e, input logic ar, input string tag);
      exp_t ex;
      exp_t got;
      @(negedge clk);
      load        = ld;
      load_val    = lv;
      en          = e;
      auto_reload = ar;
      if (ld) begin
         m_cnt = lv;
         m_rel = lv;
         m_run = (lv != 0);
         m_tc  = 1'b0;
      end else if (m_run && e) begin
         if (m_cnt > 1) begin
            m_cnt = m_cnt - 1'b1;
            m_tc  = 1'b0;
         end else if (m_cnt == 1) begin
            m_cnt = '0;
            m_tc  = 1'b1;
            m_run = ar;
         end else begin
            m_cnt = m_rel;
            m_tc  = 1'b0;
         end
      end else begin
         m_tc = 1'b0;
      end
      ex.cnt = m_cnt;
      ex.z   = (m_cnt == 0);
      ex.tc  = m_tc;
      ex.bsy = m_run;
      sb_q.push_back(ex);
      @(posedge clk);
      #1;
      got = '{cnt: count, z: zero, tc: tc_pulse, bsy: busy};
      if (sb_q.size() == 0) begin
         check_val({tag, " queue"}, 32'd0, 32'd1);
      end else begin
         ex = sb_q.pop_front();
         check_val({tag, " count"},    32'(got.cnt), 32'(ex.cnt));
         check_val({tag, " zero"},     32'(got.z),   32'(ex.z));
         check_val({tag, " tc_pulse"}, 32'(got.tc),  32'(ex.tc));
         check_val({tag, " busy"},     32'(got.bsy), 32'(ex.bsy));
      end
   endtask

`ifdef TFF_DOWN_TIMER_HEX_EN
   task automatic hex_check(input logic [WIDTH-1:0] v, input logic [6:0] exp_seg);
      step(1'b1, v, 1'b0, 1'b0, "hexload");
      check_val("hex0", 32'(hex0), 32'(exp_seg));
   endtask
`endif

   initial begin
      rst_n       = 1'b0;
      load        = 1'b0;
      load_val    = '0;
      en          = 1'b0;
      auto_reload = 1'b0;
      model_reset();
      #12;
      check_val("rst count", 32'(count),    32'd0);
      check_val("rst zero",  32'(zero),     32'd1);
      check_val("rst tc",    32'(tc_pulse), 32'd0);
      check_val("rst busy",  32'(busy),     32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Async reset mid-count at 0x05A, checked before any clock edge
      step(1'b1, 10'h05A, 1'b0, 1'b0, "ld5A");
      step(1'b0, 10'h000, 1'b1, 1'b0, "dec59");
      step(1'b1, 10'h05A, 1'b1, 1'b0, "ld5A2");
      @(posedge clk);
      #3;
      check_val("pre-arst count", 32'(count), 32'h05A);
      rst_n = 1'b0;
      #1;
      check_val("arst count", 32'(count),    32'd0);
      check_val("arst zero",  32'(zero),     32'd1);
      check_val("arst tc",    32'(tc_pulse), 32'd0);
      check_val("arst busy",  32'(busy),     32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b0;
      load  = 1'b0;

      // en ignored in IDLE
      step(1'b0, 10'h000, 1'b1, 1'b0, "idle_en");

      // One-shot from 3, then hold at zero for 5 enabled cycles
      step(1'b1, 10'd3, 1'b0, 1'b0, "os_load");
      for (int i = 0; i < 8; i++) step(1'b0, 10'h000, 1'b1, 1'b0, "oneshot");

      // Auto-reload from 2, 10 enabled cycles
      step(1'b1, 10'd2, 1'b0, 1'b1, "ar_load");
      for (int i = 0; i < 10; i++) step(1'b0, 10'h000, 1'b1, 1'b1, "autorel");

      // auto_reload only sampled on 1 -> 0: toggle it beforehand, then stop
      step(1'b1, 10'd3, 1'b0, 1'b1, "ars_load");
      step(1'b0, 10'h000, 1'b1, 1'b1, "ars_3to2");
      step(1'b0, 10'h000, 1'b1, 1'b1, "ars_2to1");
      step(1'b0, 10'h000, 1'b1, 1'b0, "ars_1to0");
      step(1'b0, 10'h000, 1'b1, 1'b1, "ars_hold");

      // Enable gating and borrow ripple across the lower bits
      step(1'b1, 10'h100, 1'b0, 1'b0, "rip_load");
      step(1'b0, 10'h000, 1'b1, 1'b0, "rip_0FF");
      step(1'b0, 10'h000, 1'b0, 1'b0, "rip_hold");
      step(1'b0, 10'h000, 1'b1, 1'b0, "rip_0FE");
      step(1'b1, 10'h3FF, 1'b0, 1'b0, "max_load");
      step(1'b0, 10'h000, 1'b1, 1'b0, "max_dec");

      // Priority: load beats the 1 -> 0 step; load of 0 goes idle
      step(1'b1, 10'd2, 1'b0, 1'b0, "pri_load");
      step(1'b0, 10'h000, 1'b1, 1'b0, "pri_to1");
      step(1'b1, 10'd7, 1'b1, 1'b0, "pri_ld7");
      step(1'b0, 10'h000, 1'b1, 1'b0, "pri_dec");
      step(1'b1, 10'd0, 1'b1, 1'b0, "pri_ld0");
      step(1'b0, 10'h000, 1'b1, 1'b1, "pri_idle");

      // tc_pulse cleared by en=0 right after terminal count in auto mode
      step(1'b1, 10'd1, 1'b0, 1'b1, "tce_load");
      step(1'b0, 10'h000, 1'b1, 1'b1, "tce_tc");
      step(1'b0, 10'h000, 1'b0, 1'b1, "tce_hold");
      step(1'b0, 10'h000, 1'b1, 1'b1, "tce_rel");

`ifdef TFF_DOWN_TIMER_HEX_EN
      hex_check(10'h000, 7'b1000000);
      hex_check(10'h001, 7'b1111001);
      hex_check(10'h00A, 7'b0001000);
      hex_check(10'h00F, 7'b0001110);
      hex_check(10'h3F5, 7'b0010010);
`endif

      check_val("sb empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tff_down_timer.md
Name: tff_down_timer

Overview:
- Synchronous N-bit down-counter/timer built from a generate chain of T flip-flops.
- It is the counting-down counterpart of the lab's TFF up-counter: it loads a preset, decrements on enable, flags terminal count, and optionally auto-reloads.
- It is intended to sit beside the up-counter on the board, driven from SW and displayed on LEDR/HEX.

Parameters:
- WIDTH, 10, counter width in bits; matches the LEDR width. Legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  preset value, captured when load=1.
- en  input  1  count enable; one decrement per clk while high.
- auto_reload  input  1  1 = restart from the preset after terminal count; 0 = stop at zero.
- count  output  WIDTH  current counter value; each bit is a TFF output.
- zero  output  1  combinational (count == 0).
- tc_pulse  output  1  registered, one-cycle pulse when count steps 1 -> 0.
- busy  output  1  high while state == RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Asserting it at any time, including mid-count, immediately forces:
  - count = 0
  - reload register = 0
  - state = IDLE
  - tc_pulse = 0
  - busy = 0
  - zero = 1
- Deassertion is synchronised externally; the block does not resynchronise rst_n.
- Counter structure: each bit q[i] is a TFF with toggle t[i].
  - t[0] = dec
  - t[i] = dec & (q[i-1:0] == 0), for i >= 1
  - dec = (state == RUN) & en & ~load & (count != 0)
  - Loads and reloads bypass the toggle path and write q directly. A plain behavioural "count - 1" is not acceptable.
- State machine, two states:
  - IDLE: count holds, busy=0, en is ignored.
  - RUN: busy=1.
- Transitions, highest priority first:
  - load=1, any state: count <= load_val and reload_reg <= load_val. Next state is RUN if load_val != 0, else IDLE. tc_pulse <= 0.
  - RUN, en=1, count > 1: count decrements by 1.
  - RUN, en=1, count == 1: count <= 0 and tc_pulse <= 1 next cycle, so the pulse coincides with zero=1. Next state is RUN if auto_reload=1, else IDLE.
  - RUN, en=1, count == 0 (auto-reload path): count <= reload_reg; stays in RUN. This gives a period of reload_reg+1 enabled cycles, including the zero cycle.
  - RUN, en=0: everything holds; busy stays 1; tc_pulse clears.
- tc_pulse is high for exactly one cycle per terminal count, even if en stays high afterwards.
- No wrap: the counter never goes 0 -> all-ones. In IDLE, and at 0 without a reload, all toggles are disabled.
- auto_reload is sampled only on the 1 -> 0 step. Changing it at any other time has no effect until the next terminal count.
- Simultaneous events:
  - load with en: load wins; no decrement that cycle.
  - load in the same cycle as the 1 -> 0 step: load wins; no tc_pulse.
- Latency: count changes one clk after the qualifying edge. zero is combinational from count.

Optional Feature:
- Macro: TFF_DOWN_TIMER_HEX_EN.
- When defined: adds output port hex0 [6:0], an active-low seven-segment decode of count[3:0].
  - Segment order {g,f,e,d,c,b,a}.
  - Hex digits 0-F; for example 0 -> 7'b1000000, 1 -> 7'b1111001, A -> 7'b0001000.
  - Purely combinational; no added latency.
- When undefined: the hex0 port and decoder are absent; all other behaviour is identical.

Test Plan:
1. Reset: drive rst_n=0 mid-count at count=0x05A, asynchronously (between clock edges) -> count=0, busy=0, tc_pulse=0, zero=1 without waiting for a clk edge.
2. One-shot: load_val=3, load one cycle, then en=1, auto_reload=0.
   - count sequence 3, 2, 1, 0.
   - tc_pulse high only in the cycle count=0.
   - busy falls together with count reaching 0.
   - count holds 0 for 5 more enabled cycles.
3. Auto-reload: load_val=2, auto_reload=1, en=1 for 10 cycles.
   - count sequence 2, 1, 0, 2, 1, 0, 2, ...
   - tc_pulse once per 3-cycle period; busy stays 1.
4. Enable gating and TFF ripple: load_val=0x100, en toggling 1,0,1.
   - count goes 0x100 -> 0x0FF (all lower bits toggle in one cycle), holds while en=0, then 0x0FE.
5. Priority: at count=1 with en=1, assert load with load_val=7 -> count=7, no tc_pulse, busy=1. A separate load with load_val=0 -> IDLE, busy=0, zero=1, tc_pulse=0.
6. With TFF_DOWN_TIMER_HEX_EN defined: count values 0, 1, 0xA, 0xF -> hex0 = 7'b1000000, 7'b1111001, 7'b0001000, 7'b0001110.
